// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RV32 control sequencer; owns the IR and drives all datapath selects/enables.
// Latency: 4 cycles for R/I-ALU/JAL/STORE, 5 for LOAD, plus any memory wait cycles.
// Backpressure: holds im_req/dm_req until ready; after WAIT_LIMIT unanswered cycles it traps (sticky until reset).
module mc_control_fsm #(
  parameter logic [31:0] RESET_IR   = 32'h00000013,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] im_rdata,
  input  logic        im_ready,
  input  logic        dm_ready,
  output logic        im_req,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  func3,
  output logic        subsra,
  output logic        rf_we,
  output logic        pc_we,
  output logic        sel_op1,
  output logic        sel_op2,
  output logic        sel_pc,
  output logic [1:0]  sel_wb,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // The counter value that, once reached without ready, means the requester gave up.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT);

  state_t      state_q;
  logic [31:0] ir_q;
  logic [7:0]  wait_cnt;
  logic        trap_q;
  logic [1:0]  cause_q;

  logic        is_r;
  logic        is_i;
  logic        is_load;
  logic        is_store;
  logic        is_jal;
  logic        is_legal;
  logic [7:0]  wait_nxt;
  logic        wait_expired;
  logic        sel_active;

  assign is_r     = (ir_q[6:0] == OP_R);
  assign is_i     = (ir_q[6:0] == OP_I);
  assign is_load  = (ir_q[6:0] == OP_LOAD);
  assign is_store = (ir_q[6:0] == OP_STORE);
  assign is_jal   = (ir_q[6:0] == OP_JAL);
  assign is_legal = is_r | is_i | is_load | is_store | is_jal;

  // This cycle is the WAIT_LIMIT-th one without ready; ready in the same cycle still wins.
  assign wait_nxt     = wait_cnt + 8'd1;
  assign wait_expired = (wait_nxt == WAIT_LAST);

  // Sequencer: state, IR capture, wait counter and sticky trap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ir_q     <= RESET_IR;
      wait_cnt <= 8'd0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q  <= S_FETCH;
          wait_cnt <= 8'd0;
        end
        S_FETCH: begin
          if (im_ready) begin
            ir_q    <= im_rdata;
            state_q <= S_DECODE;
          end else if (wait_expired) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b10;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state_q <= S_EXECUTE;
          end else begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b01;
          end
        end
        S_EXECUTE: begin
          if (is_load | is_store) begin
            state_q  <= S_MEM;
            wait_cnt <= 8'd0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dm_ready) begin
            if (is_store) begin
              state_q  <= S_FETCH;
              wait_cnt <= 8'd0;
            end else begin
              state_q <= S_WB;
            end
          end else if (wait_expired) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b11;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        S_WB: begin
          state_q  <= S_FETCH;
          wait_cnt <= 8'd0;
        end
        S_TRAP: begin
          state_q <= S_TRAP;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Memory requests and write enables follow the registered state; the async reset drops them at once.
  // A STORE retires in the MEM cycle that completes, so its PC update rides on dm_ready.
  assign im_req = (state_q == S_FETCH);
  assign dm_req = (state_q == S_MEM);
  assign dm_we  = (state_q == S_MEM) & is_store;
  assign rf_we  = (state_q == S_WB) & (ir_q[11:7] != 5'd0);
  assign pc_we  = (state_q == S_WB) | ((state_q == S_MEM) & is_store & dm_ready);

  // Selects only reflect the IR once it holds the current instruction; before that they sit at idle values.
  assign sel_active = (state_q == S_DECODE) | (state_q == S_EXECUTE) |
                      (state_q == S_MEM)    | (state_q == S_WB);

  // Per-opcode datapath select decode.
  always_comb begin
    sel_op1 = 1'b0;
    sel_op2 = 1'b0;
    sel_pc  = 1'b0;
    sel_wb  = 2'b01;
    if (sel_active) begin
      if (is_r) begin
        sel_op1 = 1'b1;
      end else if (is_i | is_store) begin
        sel_op1 = 1'b1;
        sel_op2 = 1'b1;
      end else if (is_load) begin
        sel_op1 = 1'b1;
        sel_op2 = 1'b1;
        sel_wb  = 2'b00;
      end else if (is_jal) begin
        sel_op2 = 1'b1;
        sel_pc  = 1'b1;
        sel_wb  = 2'b10;
      end
    end
  end

  assign ir         = ir_q;
  assign rs1        = ir_q[19:15];
  assign rs2        = ir_q[24:20];
  assign rd         = ir_q[11:7];
  assign func3      = ir_q[14:12];
  assign subsra     = is_r & ir_q[30];
  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: directed scenarios plus randomized instruction streams.
// The model expands each instruction into its expected per-cycle trace; one process compares every cycle.
module tb_mc_control_fsm;

  localparam int          LIM = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [2:0]  T_IDLE = 3'd0, T_FETCH = 3'd1, T_DEC = 3'd2, T_EXE = 3'd3,
                          T_MEM = 3'd4, T_WB = 3'd5, T_TRAP = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] im_rdata = 32'd0;
  logic        im_ready = 1'b0;
  logic        dm_ready = 1'b0;
  logic        im_req, dm_req, dm_we, rf_we, pc_we, subsra;
  logic        sel_op1, sel_op2, sel_pc, trap;
  logic [31:0] ir;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  func3, state;
  logic [1:0]  sel_wb, trap_cause;

  mc_control_fsm #(.RESET_IR(NOP), .WAIT_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .im_rdata(im_rdata), .im_ready(im_ready), .dm_ready(dm_ready),
    .im_req(im_req), .dm_req(dm_req), .dm_we(dm_we), .ir(ir), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func3(func3), .subsra(subsra), .rf_we(rf_we), .pc_we(pc_we), .sel_op1(sel_op1),
    .sel_op2(sel_op2), .sel_pc(sel_pc), .sel_wb(sel_wb), .state(state), .trap(trap),
    .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        im_ready;
    logic        dm_ready;
    logic [31:0] im_rdata;
    logic [2:0]  st;
    logic        im_req, dm_req, dm_we, rf_we, pc_we, trap;
    logic [1:0]  cause;
    logic [31:0] ir;
  } cyc_t;

  cyc_t        cyc_q[$];
  cyc_t        exp_c;
  bit          exp_vld = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_ir = NOP;
  logic        m_trap = 1'b0;
  logic [1:0]  m_cause = 2'b00;
  bit          m_dead = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // 0 illegal, 1 R, 2 I-ALU, 3 LOAD, 4 STORE, 5 JAL
  function automatic int cls(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return 1;
      7'b0010011: return 2;
      7'b0000011: return 3;
      7'b0100011: return 4;
      7'b1101111: return 5;
      default:    return 0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Selects table: idle values outside DECODE..WB, per-class values within.
  task automatic exp_sels(input logic [31:0] i, input logic [2:0] st,
                          output logic o1, output logic o2, output logic pc, output logic [1:0] wb);
    o1 = 1'b0; o2 = 1'b0; pc = 1'b0; wb = 2'b01;
    if (st >= T_DEC && st <= T_WB) begin
      case (cls(i))
        1: o1 = 1'b1;
        2: begin o1 = 1'b1; o2 = 1'b1; end
        3: begin o1 = 1'b1; o2 = 1'b1; wb = 2'b00; end
        4: begin o1 = 1'b1; o2 = 1'b1; end
        5: begin o2 = 1'b1; pc = 1'b1; wb = 2'b10; end
        default: ;
      endcase
    end
  endtask

  task automatic push(input logic [2:0] st, input logic ird, input logic drd, input logic [31:0] rdata,
                      input logic ireq, input logic dreq, input logic dwe, input logic rfwe, input logic pcwe);
    cyc_t c;
    c.im_ready = ird; c.dm_ready = drd; c.im_rdata = rdata; c.st = st;
    c.im_req = ireq; c.dm_req = dreq; c.dm_we = dwe; c.rf_we = rfwe; c.pc_we = pcwe;
    c.trap = m_trap; c.cause = m_cause; c.ir = m_ir;
    cyc_q.push_back(c);
  endtask

  task automatic go_trap(input logic [1:0] cause);
    m_trap = 1'b1; m_cause = cause; m_dead = 1'b1;
    repeat (3) push(T_TRAP, rb(), rb(), $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expand one instruction: di / dd are the cycles each memory withholds ready.
  task automatic add_instr(input logic [31:0] ins, input int di, input int dd);
    int c;
    for (int k = 0; k <= di; k++) begin
      if (k == di) begin
        push(T_FETCH, 1'b1, rb(), ins, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_ir = ins;
      end else begin
        push(T_FETCH, 1'b0, rb(), $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (k + 1 == LIM) begin go_trap(2'b10); return; end
      end
    end
    c = cls(ins);
    push(T_DEC, rb(), rb(), $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (c == 0) begin go_trap(2'b01); return; end
    push(T_EXE, rb(), rb(), $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (c == 3 || c == 4) begin
      for (int k = 0; k <= dd; k++) begin
        if (k == dd) begin
          push(T_MEM, rb(), 1'b1, $urandom, 1'b0, 1'b1, c == 4, 1'b0, c == 4);
        end else begin
          push(T_MEM, rb(), 1'b0, $urandom, 1'b0, 1'b1, c == 4, 1'b0, 1'b0);
          if (k + 1 == LIM) begin go_trap(2'b11); return; end
        end
      end
      if (c == 4) return;
    end
    push(T_WB, rb(), rb(), $urandom, 1'b0, 1'b0, 1'b0, ins[11:7] != 5'd0, 1'b1);
  endtask

  task automatic play();
    while (cyc_q.size() > 0) begin
      @(posedge clk); #1;
      exp_c    = cyc_q.pop_front();
      reset    = 1'b0;
      im_ready = exp_c.im_ready;
      dm_ready = exp_c.dm_ready;
      im_rdata = exp_c.im_rdata;
      exp_vld  = 1'b1;
    end
  endtask

  // Called between edges; checks the reset values without waiting for a clock.
  task automatic do_reset();
    exp_vld = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_im_req", 32'(im_req), 32'd0);
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    check("rst_ir", ir, NOP);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    check("rst_sels", {28'd0, sel_op1, sel_op2, sel_pc, 1'b0}, 32'd0);
    check("rst_sel_wb", 32'(sel_wb), 32'd1);
    m_ir = NOP; m_trap = 1'b0; m_cause = 2'b00; m_dead = 1'b0;
    push(T_IDLE, rb(), rb(), $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Single per-cycle comparison against the expected trace.
  always @(negedge clk) begin : cmp
    logic e1, e2, ep;
    logic [1:0] ew;
    if (exp_vld) begin
      check("state", 32'(state), 32'(exp_c.st));
      check("im_req", 32'(im_req), 32'(exp_c.im_req));
      check("dm_req", 32'(dm_req), 32'(exp_c.dm_req));
      if (exp_c.dm_req) check("dm_we", 32'(dm_we), 32'(exp_c.dm_we));
      check("rf_we", 32'(rf_we), 32'(exp_c.rf_we));
      check("pc_we", 32'(pc_we), 32'(exp_c.pc_we));
      check("trap", 32'(trap), 32'(exp_c.trap));
      check("trap_cause", 32'(trap_cause), 32'(exp_c.cause));
      check("ir", ir, exp_c.ir);
      check("fields", {9'd0, rs1, rs2, rd, func3, subsra, 4'd0},
            {9'd0, exp_c.ir[19:15], exp_c.ir[24:20], exp_c.ir[11:7], exp_c.ir[14:12],
             (exp_c.ir[6:0] == 7'b0110011) & exp_c.ir[30], 4'd0});
      if (exp_c.st != T_FETCH && exp_c.st != T_TRAP) begin
        exp_sels(exp_c.ir, exp_c.st, e1, e2, ep, ew);
        check("sels", {28'd0, sel_op1, sel_op2, sel_pc, 1'b0}, {28'd0, e1, e2, ep, 1'b0});
        check("sel_wb", 32'(sel_wb), 32'(ew));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int seq[6];
    logic [6:0]  ops[5];
    logic [31:0] ins;
    int di, dd, k;
    seq = '{0, 1, 2, 3, 5, 1};
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1101111};

    // add x3,x1,x2 then addi x0,x0,5
    @(negedge clk); #1; do_reset();
    add_instr(32'h002081B3, 0, 0);
    add_instr(32'h00500013, 0, 0);
    check("pin_len_add", 32'(cyc_q.size()), 32'd9);
    for (int i = 0; i < 6; i++) check("pin_seq_add", 32'(cyc_q[i].st), 32'(seq[i]));
    check("pin_add_wb", {30'd0, cyc_q[4].rf_we, cyc_q[4].pc_we}, 32'd3);
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += int'(cyc_q[i].rf_we) + int'(cyc_q[i].pc_we);
    check("pin_add_pre_wb", 32'(cnt), 32'd0);
    check("pin_x0_wb", {29'd0, cyc_q[8].st == T_WB, cyc_q[8].rf_we, cyc_q[8].pc_we}, 32'd5);
    play();

    // lw with dm_ready delayed 3 cycles (ready on the last allowed cycle)
    add_instr(32'h0040A183, 0, 3);
    cnt = 0;
    foreach (cyc_q[i]) cnt += int'(cyc_q[i].dm_req);
    check("pin_lw_dm_req_cycles", 32'(cnt), 32'd4);
    check("pin_lw_rf_after_ready", {30'd0, cyc_q[6].dm_ready, cyc_q[7].rf_we}, 32'd3);
    play();

    // sw with immediate dm_ready
    add_instr(32'h0030A223, 0, 0);
    check("pin_sw_len", 32'(cyc_q.size()), 32'd4);
    check("pin_sw_mem", {29'd0, cyc_q[3].dm_req, cyc_q[3].dm_we, cyc_q[3].pc_we}, 32'd7);
    cnt = 0;
    foreach (cyc_q[i]) cnt += int'(cyc_q[i].rf_we);
    check("pin_sw_no_rf", 32'(cnt), 32'd0);
    play();

    // illegal opcode
    @(negedge clk); #1; do_reset();
    add_instr(32'h0000007F, 0, 0);
    check("pin_ill_trap", {27'd0, cyc_q[3].st, cyc_q[3].trap, cyc_q[3].cause}, {27'd0, T_TRAP, 1'b1, 2'b01});
    play();

    // fetch timeout with im_ready held low
    @(negedge clk); #1; do_reset();
    add_instr(NOP, 10, 0);
    cnt = 0;
    foreach (cyc_q[i]) cnt += int'(cyc_q[i].st == T_FETCH);
    check("pin_im_timeout_fetches", 32'(cnt), 32'(LIM));
    check("pin_im_timeout_cause", 32'(cyc_q[5].cause), 32'd2);
    play();

    // reset asserted mid-MEM
    @(negedge clk); #1; do_reset();
    push(T_FETCH, 1'b1, 1'b0, 32'h0040A183, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    m_ir = 32'h0040A183;
    push(T_DEC, rb(), 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_EXE, rb(), 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_MEM, rb(), 1'b0, $urandom, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    play();
    @(negedge clk); #1;
    check("mid_mem_dm_req_before", 32'(dm_req), 32'd1);
    do_reset();
    add_instr(32'h002081B3, 0, 0);
    play();

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      if (m_dead) begin
        @(negedge clk); #1; do_reset();
      end
      ins = $urandom;
      k = $urandom_range(0, 99);
      if (k < 6) begin
        if (cls(ins) != 0) ins[6:0] = 7'h7F;
      end else begin
        ins[6:0] = ops[$urandom_range(0, 4)];
      end
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      di = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      dd = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      add_instr(ins, di, dd);
      play();
    end

    @(negedge clk); #1;
    exp_vld = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
